// File: rtl/wb_queue_pkg.sv
// Shared CPU types and constants for the writeback queue and its forwarding search.
package wb_queue_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int XLEN       = 32;
  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] dst;
    logic [XLEN-1:0]       data;
  } wb_entry_t;

endpackage

// File: rtl/wb_queue_fwd_match.sv
// Forwarding lookup over age-ordered queue entries (index 0 oldest); the youngest match wins.
module wb_fwd_match
  import wb_queue_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  wb_entry_t             entries_i [DEPTH],
  input  logic [DEPTH-1:0]      valid_i,
  input  logic [REG_ADDR_W-1:0] reg_i,
  output logic                  hit_o,
  output logic [XLEN-1:0]       val_o
);

  // Ascending scan so a younger match overwrites an older one.
  always_comb begin
    hit_o = 1'b0;
    val_o = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_i[i] && (reg_i != REG_ZERO) && (entries_i[i].dst == reg_i)) begin
        hit_o = 1'b1;
        val_o = entries_i[i].data;
      end
    end
  end

endmodule

// File: rtl/wb_queue.sv
// Writeback queue merging ALU and load results into one register-file write port.
// Define WB_QUEUE_FWD_EN to enable the forwarding search over queued entries.
module wb_queue
  import wb_queue_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  alu_valid,
  output logic                  alu_ready,
  input  logic [REG_ADDR_W-1:0] alu_dst,
  input  logic [XLEN-1:0]       alu_data,
  input  logic                  mem_valid,
  output logic                  mem_ready,
  input  logic [REG_ADDR_W-1:0] mem_dst,
  input  logic [XLEN-1:0]       mem_data,
  input  logic                  wb_stall,
  output logic                  wr_en,
  output logic [REG_ADDR_W-1:0] wr_reg,
  output logic [XLEN-1:0]       wr_data,
  input  logic [REG_ADDR_W-1:0] fwd_rs,
  input  logic [REG_ADDR_W-1:0] fwd_rt,
  output logic                  fwd_rs_hit,
  output logic                  fwd_rt_hit,
  output logic [XLEN-1:0]       fwd_rs_val,
  output logic [XLEN-1:0]       fwd_rt_val
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  wb_entry_t        entries_q [DEPTH];
  logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d, alu_slot;
  logic [CNT_W-1:0] count_q, count_d, free;
  logic             mem_push, alu_push;
  logic [1:0]       n_push;

  // Space comes from the registered count only; a same-cycle pop never frees a slot.
  assign free      = CNT_W'(DEPTH) - count_q;
  assign mem_ready = !rst && (free >= CNT_W'(1));
  assign alu_ready = !rst && ((free >= CNT_W'(2)) || ((free == CNT_W'(1)) && !mem_valid));

  assign mem_push = mem_valid && mem_ready && (mem_dst != REG_ZERO);
  assign alu_push = alu_valid && alu_ready && (alu_dst != REG_ZERO);
  assign n_push   = {1'b0, mem_push} + {1'b0, alu_push};
  assign alu_slot = tail_q + PTR_W'(mem_push);

  assign wr_en   = !rst && (count_q != '0) && !wb_stall;
  assign wr_reg  = (count_q != '0) ? entries_q[head_q].dst  : '0;
  assign wr_data = (count_q != '0) ? entries_q[head_q].data : '0;

  always_comb begin
    head_d  = head_q + PTR_W'(wr_en);
    tail_d  = tail_q + PTR_W'(n_push);
    count_d = count_q + CNT_W'(n_push) - CNT_W'(wr_en);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry storage is not reset; the count alone decides which slots are live.
  always_ff @(posedge clk) begin
    if (mem_push) entries_q[tail_q]   <= '{dst: mem_dst, data: mem_data};
    if (alu_push) entries_q[alu_slot] <= '{dst: alu_dst, data: alu_data};
  end

`ifdef WB_QUEUE_FWD_EN
  wb_entry_t        age_entries [DEPTH];
  logic [DEPTH-1:0] age_valid;
  logic             rs_hit, rt_hit;
  logic [XLEN-1:0]  rs_val, rt_val;

  always_comb begin
    for (int k = 0; k < DEPTH; k++) begin
      age_entries[k] = entries_q[head_q + PTR_W'(k)];
      age_valid[k]   = CNT_W'(k) < count_q;
    end
  end

  wb_fwd_match #(.DEPTH(DEPTH)) u_fwd_rs (
    .entries_i (age_entries),
    .valid_i   (age_valid),
    .reg_i     (fwd_rs),
    .hit_o     (rs_hit),
    .val_o     (rs_val)
  );

  wb_fwd_match #(.DEPTH(DEPTH)) u_fwd_rt (
    .entries_i (age_entries),
    .valid_i   (age_valid),
    .reg_i     (fwd_rt),
    .hit_o     (rt_hit),
    .val_o     (rt_val)
  );

  assign fwd_rs_hit = !rst && rs_hit;
  assign fwd_rt_hit = !rst && rt_hit;
  assign fwd_rs_val = fwd_rs_hit ? rs_val : '0;
  assign fwd_rt_val = fwd_rt_hit ? rt_val : '0;
`else
  logic unused_fwd;
  assign unused_fwd = ^{fwd_rs, fwd_rt};
  assign fwd_rs_hit = 1'b0;
  assign fwd_rt_hit = 1'b0;
  assign fwd_rs_val = '0;
  assign fwd_rt_val = '0;
`endif

endmodule

// File: tb/tb_wb_queue.sv
// Bench for wb_queue: directed scenarios then random traffic against a queue-based model.
// Forwarding expectations follow WB_QUEUE_FWD_EN as defined for the build.
module tb_wb_queue;

  localparam int DEPTH = 4;
`ifdef WB_QUEUE_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        alu_valid, alu_ready, mem_valid, mem_ready, wb_stall, wr_en;
  logic [4:0]  alu_dst, mem_dst, wr_reg, fwd_rs, fwd_rt;
  logic [31:0] alu_data, mem_data, wr_data, fwd_rs_val, fwd_rt_val;
  logic        fwd_rs_hit, fwd_rt_hit;

  int n_pass  = 0;
  int n_total = 0;

  typedef struct {
    logic [4:0]  dst;
    logic [31:0] data;
  } ent_t;
  ent_t q[$];

  always #5 clk = ~clk;

  wb_queue #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_dst(alu_dst), .alu_data(alu_data),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_dst(mem_dst), .mem_data(mem_data),
    .wb_stall(wb_stall), .wr_en(wr_en), .wr_reg(wr_reg), .wr_data(wr_data),
    .fwd_rs(fwd_rs), .fwd_rt(fwd_rt),
    .fwd_rs_hit(fwd_rs_hit), .fwd_rt_hit(fwd_rt_hit),
    .fwd_rs_val(fwd_rs_val), .fwd_rt_val(fwd_rt_val)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Youngest queued entry whose dst matches; register 0 never matches.
  task automatic lookup(input logic [4:0] r, output bit hit, output logic [31:0] val);
    hit = 1'b0;
    val = '0;
    if (r != 5'd0) begin
      for (int i = q.size() - 1; i >= 0; i--) begin
        if (q[i].dst == r) begin
          hit = 1'b1;
          val = q[i].data;
          break;
        end
      end
    end
  endtask

  task automatic step(input bit r, input bit av, input logic [4:0] ad, input logic [31:0] adt,
                      input bit mv, input logic [4:0] md, input logic [31:0] mdt,
                      input bit st, input logic [4:0] rs, input logic [4:0] rt);
    int          sz, fr;
    bit          e_mr, e_ar, e_we, rs_h, rt_h;
    logic [31:0] rs_v, rt_v;
    rst = r; alu_valid = av; alu_dst = ad; alu_data = adt;
    mem_valid = mv; mem_dst = md; mem_data = mdt;
    wb_stall = st; fwd_rs = rs; fwd_rt = rt;
    @(negedge clk);
    sz   = q.size();
    fr   = DEPTH - sz;
    e_mr = !r && (fr >= 1);
    e_ar = !r && ((fr >= 2) || (fr == 1 && !mv));
    e_we = !r && (sz != 0) && !st;
    check("mem_ready", 32'(mem_ready), 32'(e_mr));
    check("alu_ready", 32'(alu_ready), 32'(e_ar));
    check("wr_en", 32'(wr_en), 32'(e_we));
    if (!r || sz == 0) begin
      check("wr_reg", 32'(wr_reg), (sz != 0) ? 32'(q[0].dst) : 32'd0);
      check("wr_data", wr_data, (sz != 0) ? q[0].data : 32'd0);
    end
    lookup(rs, rs_h, rs_v);
    lookup(rt, rt_h, rt_v);
    rs_h = rs_h && FWD && !r;
    rt_h = rt_h && FWD && !r;
    check("fwd_rs_hit", 32'(fwd_rs_hit), 32'(rs_h));
    check("fwd_rt_hit", 32'(fwd_rt_hit), 32'(rt_h));
    check("fwd_rs_val", fwd_rs_val, rs_h ? rs_v : 32'd0);
    check("fwd_rt_val", fwd_rt_val, rt_h ? rt_v : 32'd0);
    @(posedge clk);
    if (r) q.delete();
    else begin
      if (e_we) void'(q.pop_front());
      if (mv && e_mr && md != 5'd0) q.push_back('{dst: md, data: mdt});
      if (av && e_ar && ad != 5'd0) q.push_back('{dst: ad, data: adt});
    end
    #1;
  endtask

  task automatic idle(input bit st, input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, st, 0, 0);
  endtask

  initial begin
    rst = 1'b1; alu_valid = 0; mem_valid = 0; alu_dst = 0; mem_dst = 0;
    alu_data = 0; mem_data = 0; wb_stall = 0; fwd_rs = 0; fwd_rt = 0;
    #1;
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 1, 5, 32'h5, 1, 6, 32'h6, 0, 0, 0);

    // Single ALU result written back one cycle later, then queue empty.
    step(0, 1, 5, 32'h1234, 0, 0, 0, 0, 0, 0);
    idle(0, 2);

    // Simultaneous mem and ALU: mem is older.
    step(0, 1, 4, 32'hBBBB, 1, 3, 32'hAAAA, 0, 0, 0);
    idle(0, 3);

    // Stalled fill: at count 3 mem wins the last slot, then full.
    step(0, 1, 1, 32'h1, 0, 0, 0, 1, 0, 0);
    step(0, 1, 2, 32'h2, 0, 0, 0, 1, 0, 0);
    step(0, 1, 3, 32'h3, 0, 0, 0, 1, 0, 0);
    step(0, 1, 9, 32'h9, 1, 4, 32'h4, 1, 0, 0);
    step(0, 1, 9, 32'h9, 1, 8, 32'h8, 1, 0, 0);
    idle(0, 5);

    // dst 0 is accepted and dropped.
    step(0, 1, 0, 32'hFFFF, 0, 0, 0, 0, 0, 0);
    idle(0, 2);

    // Two writes to the same register: youngest value forwards.
    step(0, 1, 7, 32'h11, 0, 0, 0, 1, 0, 0);
    step(0, 1, 7, 32'h22, 0, 0, 0, 1, 7, 0);
    step(0, 0, 0, 0, 0, 0, 0, 1, 7, 0);
    idle(0, 3);

    // Reset with entries queued: nothing survives.
    step(0, 1, 10, 32'hA, 1, 11, 32'hB, 1, 0, 0);
    step(0, 1, 12, 32'hC, 0, 0, 0, 1, 11, 12);
    step(1, 0, 0, 0, 0, 0, 0, 1, 11, 12);
    idle(0, 3);

    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 99) == 0),
           $urandom_range(0, 1), 5'($urandom_range(0, 7)), $urandom,
           $urandom_range(0, 1), 5'($urandom_range(0, 7)), $urandom,
           ($urandom_range(0, 9) < 3),
           5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
    end
    idle(0, 6);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/wb_queue.md
WB_QUEUE -- requirements
Module: wb_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning the number of buffered writeback entries (power of two, minimum 2).
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1, a synchronous, active-high reset.
REQ-004 SHALL have port alu_valid, input, 1, meaning the ALU result is offered this cycle.
REQ-005 SHALL have port alu_ready, output, 1, meaning the ALU result is accepted this cycle.
REQ-006 SHALL have ports alu_dst (input, 5, destination register) and alu_data (input, 32, result value).
REQ-007 SHALL have ports mem_valid (input, 1), mem_ready (output, 1), mem_dst (input, 5) and mem_data (input, 32), with the same meanings for load results.
REQ-008 SHALL have port wb_stall, input, 1, meaning the register-file write port cannot take a write this cycle.
REQ-009 SHALL have ports wr_en (output, 1), wr_reg (output, 5) and wr_data (output, 32), which drive the register-file write port.
REQ-010 SHALL have ports fwd_rs and fwd_rt (input, 5 each), which are lookup register numbers.
REQ-011 SHALL have ports fwd_rs_hit and fwd_rt_hit (output, 1 each) and fwd_rs_val and fwd_rt_val (output, 32 each).

Function
REQ-012 SHALL implement a circular FIFO of DEPTH entries {dst[4:0], data[31:0]}, with head/tail pointers and a count of width clog2(DEPTH)+1.
REQ-013 SHALL define free = DEPTH - count, using the registered count; pops in the same cycle SHALL NOT add space.
REQ-014 SHALL drive mem_ready = (free >= 1).
REQ-015 SHALL drive alu_ready = (free >= 2) or (free == 1 and not mem_valid).
- Consequence: mem has priority when only one slot is free.
REQ-016 SHALL define a transfer on a port as valid and ready in the same cycle.
REQ-017 SHALL accept a transfer with dst == 0 but SHALL NOT enqueue it (register $0 is never written).
REQ-018 SHALL, when both ports transfer in the same cycle, enqueue the mem entry at tail and the ALU entry at tail+1, so mem is older.
REQ-019 SHALL drive wr_en = (count != 0) and not wb_stall, combinationally, with wr_reg and wr_data taken from the head entry.
REQ-020 SHALL pop the head entry on every cycle in which wr_en is 1.
REQ-021 SHALL have a latency of one cycle: an entry enqueued at edge N appears on wr_* during cycle N+1 if it is at the head.
REQ-022 SHALL wrap the pointers modulo DEPTH.
REQ-023 SHALL update count by +pushes - pop, with pushes in 0..2 and pop in 0..1.
REQ-024 SHALL handle a push and a pop in the same cycle while full as legal only via REQ-013, so count never exceeds DEPTH.
REQ-025 SHALL hold wr_reg/wr_data at 0 whenever count == 0.

Reset
REQ-026 SHALL, while rst is 1 at a clock edge, clear the head, tail and count.
- Entry contents need not be cleared.
REQ-027 SHALL drive wr_en=0, alu_ready=0, mem_ready=0 and all fwd hits = 0 during any cycle in which rst is 1.
REQ-028 SHALL discard all in-flight entries on reset mid-operation, with no write on the following cycle.

Configuration
REQ-029 SHALL, with WB_QUEUE_FWD_EN defined, search the valid entries youngest-to-oldest for dst == fwd_rs and dst == fwd_rt.
- On a match: hit = 1, val = the youngest matching data.
- fwd_rs or fwd_rt == 0: never a hit.
- The search is combinational, on registered state only.
REQ-030 SHALL, without WB_QUEUE_FWD_EN, keep the fwd ports present, drive all hit and val outputs to 0, and include no search logic.

Structure
REQ-031 SHALL place in the shared CPU package:
- the typedef wb_entry_t {dst[4:0], data[31:0]};
- the constants REG_ZERO = 5'd0, REG_ADDR_W = 5 and XLEN = 32.
REQ-032 SHALL implement the forwarding search as the sub-module wb_fwd_match, which takes the entry array, valid mask and lookup register, and returns hit and value.
- Instantiated twice: once for rs, once for rt.

Verification
REQ-033 SHALL pass this scenario: reset, ALU {dst=5, data=0x1234} for one cycle -> wr_en=1, wr_reg=5, wr_data=0x1234 on the next cycle, then count=0.
REQ-034 SHALL pass this scenario: both ports valid in the same cycle, mem {3,0xAAAA} and ALU {4,0xBBBB}, with wb_stall=0 -> wr_reg=3 then wr_reg=4 on consecutive cycles.
REQ-035 SHALL pass this scenario: wb_stall=1, fill with {1..4} -> mem_ready=0 at count=4.
- At count=3 with both valid: mem_ready=1, alu_ready=0.
- Release the stall -> writes appear in order 1,2,3,4.
REQ-036 SHALL pass this scenario: ALU dst=0, data=0xFFFF -> alu_ready=1, count unchanged, wr_en remains 0.
REQ-037 SHALL pass this scenario (WB_QUEUE_FWD_EN): wb_stall=1, enqueue {7,0x11} then {7,0x22}, set fwd_rs=7 -> fwd_rs_hit=1 and fwd_rs_val=0x22; fwd_rt=0 -> fwd_rt_hit=0.
REQ-038 SHALL pass this scenario: 3 entries queued, assert rst for one cycle -> wr_en=0 after reset, count=0, and no stale write.
